core_instr_mem_axil: RTL and testbench
======================================

# core_instr_mem_axil

AXI-lite read-only instruction memory slave that sits directly upstream of the core fetch stage and serves its AR/R requests. It accepts a word address on the AR channel, waits a configurable number of cycles, then returns one 32-bit instruction on the R channel, holding it until the fetch stage accepts it. A side-band program-load port lets the testbench or debug logic write instruction words without using AXI.

## Interface
- ADDR_WIDTH, 32, width of ARADDR and prog_addr; both carry **word** addresses (byte PC >> 2).
- DATA_WIDTH, 32, instruction/data word width.
- DEPTH_WORDS, 1024, number of memory words; power of two, at least 2.
- READ_LATENCY, 1, cycles from AR handshake to RVALID; legal range 1..8.
- INIT_FILE, "", hex file loaded with $readmemh at elaboration when non-empty.
- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- ARADDR  in  ADDR_WIDTH  word address of the read request.
- ARVALID  in  1  read request valid.
- ARREADY  out  1  slave can accept a request.
- RDATA  out  DATA_WIDTH  returned instruction.
- RRESP  out  2  2'b00 OKAY, 2'b10 SLVERR.
- RVALID  out  1  RDATA/RRESP valid.
- RREADY  in  1  master accepts the response.
- prog_we  in  1  program-load write enable.
- prog_addr  in  ADDR_WIDTH  program-load word address.
- prog_wdata  in  DATA_WIDTH  program-load data.

## Operation
- Reset (rst low, asynchronous): state IDLE_RST, ARREADY=0, RVALID=0, RDATA=0, RRESP=2'b00, latency counter=0. Memory contents are not reset.
- **IDLE_RST → IDLE:** taken on the first rising edge with rst high. From this edge, ARREADY=1.
- **IDLE:** ARREADY=1.
  - If ARVALID is sampled high, capture ARADDR.
  - Load the counter with READ_LATENCY-1.
  - Set ARREADY=0 and go to WAIT.
- **WAIT:** ARREADY=0, RVALID=0.
  - While counter ≠ 0, decrement it.
  - When counter = 0, read the captured address, load RDATA/RRESP, set RVALID=1, and go to RESP.
- **RESP:** RVALID=1. RDATA and RRESP stay stable until the R handshake.
  - On RVALID & RREADY: RVALID=0, ARREADY=1, go to IDLE.
- **Out-of-range address** (captured address ≥ DEPTH_WORDS): RDATA=32'h0000_0013 (NOP) and RRESP=2'b10. In range: RRESP=2'b00.
- **Address indexing:** the memory index is the captured address's low $clog2(DEPTH_WORDS) bits, used only when in range. There is no wrap-around aliasing.
- **Program load:** when prog_we is high and prog_addr < DEPTH_WORDS, mem[prog_addr] ← prog_wdata on the edge. Out-of-range writes are dropped silently.
- **Write/read collision:** a prog_we write to the same word on the same edge that loads RDATA returns the old word (read-before-write). Writes after RDATA is loaded never change a held response.
- **Ignored inputs:** ARVALID is ignored outside IDLE. Only one request is ever outstanding.

## Timing
- AR handshake is sampled at edge N. RVALID rises after edge N+READ_LATENCY.
  - With READ_LATENCY=1, RVALID is high in the cycle right after the handshake.
- R handshake at edge M clears RVALID. ARREADY is 1 in the cycle after M. The next AR handshake is at edge M+1 at the earliest.
- Minimum request-to-request period is READ_LATENCY+2 cycles. With RREADY held high it is exactly that.
- RREADY high before RVALID rises is legal. The response completes on the first edge with both high.
- Reset asserted mid-transaction (WAIT or RESP) aborts it immediately. No response is produced afterwards.
- No combinational paths from inputs to outputs. All outputs are registered.

## Test plan
- **Reset values:** hold rst low for 3 cycles, then release. ARREADY, RVALID, RDATA and RRESP are 0 during reset. ARREADY is 1 one edge after release.
- **Basic read, READ_LATENCY=1:**
  - Load mem[5]=32'h00500093 via prog_we. Issue ARADDR=5 with RREADY=1.
  - Expect RVALID high exactly 1 cycle after the handshake, RDATA=32'h00500093, RRESP=0.
  - Expect ARREADY high the cycle after the R handshake.
- **Back-pressure, READ_LATENCY=3:** keep RREADY=0 for 5 cycles after RVALID rises. RVALID and RDATA stay stable throughout. Writing mem[ARADDR] during this window leaves RDATA unchanged.
- **Out of range:** ARADDR=DEPTH_WORDS (1024) gives RDATA=32'h00000013 and RRESP=2'b10. ARADDR=1023 gives RRESP=2'b00.
- **Stream:** issue 16 sequential addresses 0..15 with ARVALID held high and RREADY=1. Responses arrive in order, matching the INIT_FILE contents. Requests are spaced READ_LATENCY+2 cycles apart, and there is never more than one outstanding.
- **Abort:** assert rst low in WAIT, then release. No RVALID appears. The next request completes normally.

Source files
------------

// File: rtl/core_instr_mem_axil.sv
// Read-only AXI-lite instruction memory for the fetch stage.
// One request is outstanding at a time. Responses appear READ_LATENCY cycles
// after the AR handshake and are held until RREADY.
// A side-band program-load port writes words without going through AXI.
module core_instr_mem_axil #(
  parameter int    ADDR_WIDTH   = 32,
  parameter int    DATA_WIDTH   = 32,
  parameter int    DEPTH_WORDS  = 1024,
  parameter int    READ_LATENCY = 1,
  parameter string INIT_FILE    = ""
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] ARADDR,
  input  logic                  ARVALID,
  output logic                  ARREADY,
  output logic [DATA_WIDTH-1:0] RDATA,
  output logic [1:0]            RRESP,
  output logic                  RVALID,
  input  logic                  RREADY,
  input  logic                  prog_we,
  input  logic [ADDR_WIDTH-1:0] prog_addr,
  input  logic [DATA_WIDTH-1:0] prog_wdata
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int CNT_W = 3;
  localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH+1)'(DEPTH_WORDS);
  localparam logic [CNT_W-1:0]      LAT_LOAD  = CNT_W'(READ_LATENCY - 1);
  localparam logic [DATA_WIDTH-1:0] NOP_WORD  = DATA_WIDTH'(32'h0000_0013);
  localparam logic [1:0]            RESP_OKAY   = 2'b00;
  localparam logic [1:0]            RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {IDLE_RST, IDLE, WAIT, RESP} state_t;

  // Response payload as it is loaded into the R channel registers.
  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [1:0]            resp;
  } rsp_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] araddr_q;
  logic [CNT_W-1:0]      cnt;
  logic                  ar_hs, r_hs, rd_fire;
  logic                  rd_in_range, wr_in_range;
  rsp_t                  rsp_nxt;

  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

  assign ar_hs       = (state == IDLE) && ARVALID;
  assign r_hs        = (state == RESP) && RREADY;
  assign rd_fire     = (state == WAIT) && (cnt == '0);
  // Full-width compare: addresses past the array return an error, never alias.
  assign rd_in_range = {1'b0, araddr_q}  < DEPTH_EXT;
  assign wr_in_range = {1'b0, prog_addr} < DEPTH_EXT;

  // Read-before-write: this read sees the array before any same-edge write.
  always_comb begin
    rsp_nxt.data = NOP_WORD;
    rsp_nxt.resp = RESP_SLVERR;
    if (rd_in_range) begin
      rsp_nxt.data = mem[araddr_q[IDX_W-1:0]];
      rsp_nxt.resp = RESP_OKAY;
    end
  end

  // State register; reset aborts any in-flight request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE_RST;
    else      state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE_RST: state_nxt = IDLE;
      IDLE:     if (ar_hs)   state_nxt = WAIT;
      WAIT:     if (rd_fire) state_nxt = RESP;
      RESP:     if (r_hs)    state_nxt = IDLE;
      default:  state_nxt = IDLE_RST;
    endcase
  end

  // Handshake outputs decode the state register directly, so no input reaches them.
  always_comb begin
    ARREADY = 1'b0;
    RVALID  = 1'b0;
    case (state)
      IDLE:    ARREADY = 1'b1;
      RESP:    RVALID  = 1'b1;
      default: ;
    endcase
  end

  // Request capture, latency countdown, and response load (held through RESP).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      araddr_q <= '0;
      cnt      <= '0;
      RDATA    <= '0;
      RRESP    <= RESP_OKAY;
    end else if (ar_hs) begin
      araddr_q <= ARADDR;
      cnt      <= LAT_LOAD;
    end else if (state == WAIT) begin
      if (cnt != '0) begin
        cnt <= cnt - 1'b1;
      end else begin
        RDATA <= rsp_nxt.data;
        RRESP <= rsp_nxt.resp;
      end
    end
  end

  // Program-load port; out-of-range writes are dropped.
  always_ff @(posedge clk) begin
    if (prog_we && wr_in_range) mem[prog_addr[IDX_W-1:0]] <= prog_wdata;
  end

endmodule

// File: tb/tb_core_instr_mem_axil.sv
// Directed bench: one instance at READ_LATENCY=1, one at READ_LATENCY=3.
// Reset and the program-load port are shared; each has its own AXI channels.
// Inputs change and outputs are sampled on the falling edge.
module tb_core_instr_mem_axil;

  logic        clk = 1'b0;
  logic        rst;
  logic        prog_we;
  logic [31:0] prog_addr, prog_wdata;

  logic [31:0] araddr [2];
  logic        arvalid[2];
  logic        arready[2];
  logic [31:0] rdata  [2];
  logic [1:0]  rresp  [2];
  logic        rvalid [2];
  logic        rready [2];

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  core_instr_mem_axil #(.READ_LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst),
    .ARADDR(araddr[0]), .ARVALID(arvalid[0]), .ARREADY(arready[0]),
    .RDATA(rdata[0]), .RRESP(rresp[0]), .RVALID(rvalid[0]), .RREADY(rready[0]),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_wdata(prog_wdata)
  );

  core_instr_mem_axil #(.READ_LATENCY(3)) u_l3 (
    .clk(clk), .rst(rst),
    .ARADDR(araddr[1]), .ARVALID(arvalid[1]), .ARREADY(arready[1]),
    .RDATA(rdata[1]), .RRESP(rresp[1]), .RVALID(rvalid[1]), .RREADY(rready[1]),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_wdata(prog_wdata)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  function automatic logic [31:0] pat(input int i);
    return 32'h1000_0000 + 32'(i) * 32'h111;
  endfunction

  // Enters and leaves on a falling edge.
  task automatic prog(input int a, input logic [31:0] d);
    prog_we = 1'b1; prog_addr = 32'(a); prog_wdata = d;
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  // Single read with RREADY high; checks latency, payload and return to idle.
  task automatic rd(input int d, input int a, input int lat,
                    input logic [31:0] exp_d, input logic [1:0] exp_r, input string tag);
    int k;
    chk({tag, "_arready"}, 32'(arready[d]), 32'd1);
    araddr[d] = 32'(a); arvalid[d] = 1'b1; rready[d] = 1'b1;
    @(negedge clk);
    arvalid[d] = 1'b0;
    k = 0;
    while (!rvalid[d] && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_lat"},   32'(k), 32'(lat));
    chk({tag, "_rdata"}, rdata[d], exp_d);
    chk({tag, "_rresp"}, 32'(rresp[d]), 32'(exp_r));
    @(negedge clk);
    chk({tag, "_rvalid_clr"}, 32'(rvalid[d]), 32'd0);
    chk({tag, "_arready_back"}, 32'(arready[d]), 32'd1);
  endtask

  // 16 back-to-back reads with ARVALID and RREADY held high.
  task automatic stream(input int d, input int lat);
    int issued, got, last_hs, max_out;
    logic hs;
    issued = 0; got = 0; last_hs = 0; max_out = 0;
    araddr[d] = 32'd0; arvalid[d] = 1'b1; rready[d] = 1'b1;
    for (int c = 0; c < 400 && got < 16; c++) begin
      hs = 1'b0;
      if (rvalid[d]) begin
        chk($sformatf("stream%0d_data%0d", d, got), rdata[d], pat(got));
        got++;
      end
      if (arready[d] && issued < 16) begin
        if (issued > 0) chk($sformatf("stream%0d_gap", d), 32'(c - last_hs), 32'(lat + 2));
        last_hs = c;
        issued++;
        hs = 1'b1;
      end
      if (issued - got > max_out) max_out = issued - got;
      @(negedge clk);
      if (hs) begin
        araddr[d] = 32'(issued);
        if (issued == 16) arvalid[d] = 1'b0;
      end
    end
    arvalid[d] = 1'b0;
    chk($sformatf("stream%0d_count", d), 32'(got), 32'd16);
    chk($sformatf("stream%0d_outstanding", d), 32'(max_out), 32'd1);
  endtask

  initial begin
    int k;
    logic seen;
    rst = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_wdata = '0;
    for (int d = 0; d < 2; d++) begin
      araddr[d] = '0; arvalid[d] = 1'b0; rready[d] = 1'b0;
    end

    // Reset values, held for three cycles.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_arready", 32'(arready[0]), 32'd0);
      chk("rst_rvalid",  32'(rvalid[0]),  32'd0);
      chk("rst_rdata",   rdata[0],        32'd0);
      chk("rst_rresp",   32'(rresp[0]),   32'd0);
    end
    chk("rst_l3_arready", 32'(arready[1]), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_arready", 32'(arready[0]), 32'd1);
    chk("post_rst_l3_arready", 32'(arready[1]), 32'd1);

    // Basic read.
    prog(5, 32'h0050_0093);
    rd(0, 5, 1, 32'h0050_0093, 2'b00, "basic");

    // Write on the same edge that loads RDATA returns the old word.
    prog(9, 32'hAAAA_0009);
    araddr[0] = 32'd9; arvalid[0] = 1'b1; rready[0] = 1'b1;
    @(negedge clk);
    arvalid[0] = 1'b0;
    prog_we = 1'b1; prog_addr = 32'd9; prog_wdata = 32'hBBBB_0009;
    @(negedge clk);
    prog_we = 1'b0;
    chk("coll_rvalid", 32'(rvalid[0]), 32'd1);
    chk("coll_rdata", rdata[0], 32'hAAAA_0009);
    @(negedge clk);
    rd(0, 9, 1, 32'hBBBB_0009, 2'b00, "coll_after");

    // Back-pressure at READ_LATENCY=3 with a write to the held word.
    prog(7, 32'h1111_0007);
    araddr[1] = 32'd7; arvalid[1] = 1'b1; rready[1] = 1'b0;
    @(negedge clk);
    arvalid[1] = 1'b0;
    k = 0;
    while (!rvalid[1] && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("bp_lat", 32'(k), 32'd3);
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        prog_we = 1'b1; prog_addr = 32'd7; prog_wdata = 32'h2222_0007;
      end
      @(negedge clk);
      prog_we = 1'b0;
      chk("bp_rvalid", 32'(rvalid[1]), 32'd1);
      chk("bp_rdata", rdata[1], 32'h1111_0007);
      chk("bp_arready", 32'(arready[1]), 32'd0);
    end
    rready[1] = 1'b1;
    @(negedge clk);
    chk("bp_rvalid_clr", 32'(rvalid[1]), 32'd0);
    chk("bp_arready_back", 32'(arready[1]), 32'd1);
    rd(1, 7, 3, 32'h2222_0007, 2'b00, "bp_after");

    // Range boundaries; an out-of-range write must not alias onto word 0.
    prog(0, 32'h0000_0A0A);
    prog(1024, 32'hDEAD_0000);
    prog(1023, 32'h0000_3FF3);
    rd(0, 1024, 1, 32'h0000_0013, 2'b10, "oor_1024");
    rd(0, 1029, 1, 32'h0000_0013, 2'b10, "oor_1029");
    rd(0, 1023, 1, 32'h0000_3FF3, 2'b00, "inr_1023");
    rd(0, 0,    1, 32'h0000_0A0A, 2'b00, "no_alias");

    // Streams.
    for (int i = 0; i < 16; i++) prog(i, pat(i));
    stream(0, 1);
    @(negedge clk);
    stream(1, 3);
    @(negedge clk);

    // Reset in WAIT aborts the request.
    araddr[1] = 32'd3; arvalid[1] = 1'b1; rready[1] = 1'b1;
    @(negedge clk);
    arvalid[1] = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_rvalid", 32'(rvalid[1]), 32'd0);
    chk("abort_arready", 32'(arready[1]), 32'd0);
    rst = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rvalid[1]) seen = 1'b1;
    end
    chk("abort_no_resp", 32'(seen), 32'd0);
    rd(1, 3, 3, pat(3), 2'b00, "abort_next");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
